// File: rtl/rf_acq_sequencer.sv
// rf_acq_sequencer: sequences the 4-channel RF sample reader ahead of the
// envelope-detection datapath. It rewinds the reader, paces its advance
// strobe at a programmable interval while honouring downstream back-pressure,
// and slices the sample stream into lines and frames.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, abort        frame request (IDLE only) / frame termination
//   cfg_samples/lines   samples per line, lines per frame (0 acts as 1)
//   cfg_div, cfg_gap    strobe interval minus 1 (0 acts as 1), idle cycles between lines
//   dn_ready            downstream can take a sample this cycle
//   rf_rst, inc_count   reader reset and advance strobe
//   sample_valid        reader outputs hold the sample at rf_addr this cycle
//   rf_addr             shadow of the reader address
//   sample_idx/line_idx position of the current sample within the frame
//   line_start/line_end first/last sample of a line
//   frame_done, busy    normal completion pulse, not-idle flag
//
// state  | meaning
// IDLE   | waiting for start
// REWIND | reader held in reset, address returns to 0
// SETTLE | reader outputs settle on address 0, divider loaded
// RUN    | strobes paced by the divider, gated by dn_ready
// GAP    | strobe-free cycles between lines
// DONE   | frame complete, back to IDLE
module rf_acq_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 8,
  parameter int DIV_W   = 8,
  parameter int RF_WRAP = 24099
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_samples,
  input  logic [LINE_W-1:0] cfg_lines,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_gap,
  input  logic              dn_ready,
  output logic              rf_rst,
  output logic              inc_count,
  output logic              sample_valid,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [ADDR_W-1:0] sample_idx,
  output logic [LINE_W-1:0] line_idx,
  output logic              line_start,
  output logic              line_end,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_SETTLE, S_RUN, S_GAP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] samples_q, samples_d;
  logic [LINE_W-1:0] lines_q, lines_d;
  logic [DIV_W-1:0]  div_cfg_q, div_cfg_d;
  logic [DIV_W-1:0]  gap_cfg_q, gap_cfg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] sample_idx_q, sample_idx_d;
  logic [LINE_W-1:0] line_idx_q, line_idx_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic              frame_done_q, frame_done_d;
  logic              strobe;
  logic              last_sample;
  logic              last_line;

  assign last_sample = (sample_idx_q == samples_q - ADDR_W'(1));
  assign last_line   = (line_idx_q == lines_q - LINE_W'(1));

  always_comb begin
    state_d      = state_q;
    samples_d    = samples_q;
    lines_d      = lines_q;
    div_cfg_d    = div_cfg_q;
    gap_cfg_d    = gap_cfg_q;
    div_d        = div_q;
    gap_d        = gap_q;
    sample_idx_d = sample_idx_q;
    line_idx_d   = line_idx_q;
    frame_done_d = 1'b0;
    strobe       = 1'b0;
    rf_rst       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          samples_d    = (cfg_samples == '0) ? ADDR_W'(1) : cfg_samples;
          lines_d      = (cfg_lines == '0) ? LINE_W'(1) : cfg_lines;
          div_cfg_d    = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
          gap_cfg_d    = cfg_gap;
          sample_idx_d = '0;
          line_idx_d   = '0;
          state_d      = S_REWIND;
        end
      end
      S_REWIND: begin
        rf_rst  = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        div_d   = div_cfg_q;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else if (dn_ready) begin
          strobe = 1'b1;
          div_d  = div_cfg_q;
          if (last_sample) begin
            sample_idx_d = '0;
            if (last_line) begin
              state_d = S_DONE;
            end else begin
              line_idx_d = line_idx_q + LINE_W'(1);
              if (gap_cfg_q != '0) begin
                gap_d   = gap_cfg_q;
                state_d = S_GAP;
              end
            end
          end else begin
            sample_idx_d = sample_idx_q + ADDR_W'(1);
          end
        end
      end
      S_GAP: begin
        // The divider keeps counting here, so the strobe spacing across a
        // gap is the larger of the gap and the sample interval.
        if (div_q != '0) div_d = div_q - DIV_W'(1);
        gap_d = gap_q - DIV_W'(1);
        if (gap_q == DIV_W'(1)) state_d = S_RUN;
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      rf_rst       = 1'b1;
      strobe       = 1'b0;
      frame_done_d = 1'b0;
      sample_idx_d = sample_idx_q;
      line_idx_d   = line_idx_q;
    end

    // Mirrors the reader: reset wins, then the unconditional wrap, then advance.
    if (rf_rst)                              rf_addr_d = '0;
    else if (rf_addr_q == ADDR_W'(RF_WRAP))  rf_addr_d = '0;
    else if (strobe)                         rf_addr_d = rf_addr_q + ADDR_W'(1);
    else                                     rf_addr_d = rf_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      samples_q    <= '0;
      lines_q      <= '0;
      div_cfg_q    <= '0;
      gap_cfg_q    <= '0;
      div_q        <= '0;
      gap_q        <= '0;
      sample_idx_q <= '0;
      line_idx_q   <= '0;
      rf_addr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      samples_q    <= samples_d;
      lines_q      <= lines_d;
      div_cfg_q    <= div_cfg_d;
      gap_cfg_q    <= gap_cfg_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      sample_idx_q <= sample_idx_d;
      line_idx_q   <= line_idx_d;
      rf_addr_q    <= rf_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign inc_count    = strobe;
  assign sample_valid = strobe;
  assign rf_addr      = rf_addr_q;
  assign sample_idx   = sample_idx_q;
  assign line_idx     = line_idx_q;
  assign line_start   = strobe && (sample_idx_q == '0);
  assign line_end     = strobe && last_sample;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q != S_IDLE);

endmodule
